// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch sequencer.
package fetch_pkg;

    localparam int FETCH_XLEN            = 32;
    localparam int FETCH_MAX_OUTSTANDING = 2;
    localparam int FETCH_PTR_W           = $clog2(FETCH_MAX_OUTSTANDING);

    // One in-order fetch slot: address issued, returned word, and whether it came back.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] data;
        logic                  filled;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        JALR_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch entry storage: allocate at tail on issue, fill oldest unfilled
// entry on response, pop from head on delivery. Pointers wrap naturally.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int size  = FETCH_XLEN,
    parameter  int DEPTH = FETCH_MAX_OUTSTANDING,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [size-1:0]  push_pc,
    input  logic             fill,
    input  logic [size-1:0]  fill_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] unfilled,
    output logic             head_filled,
    output logic [size-1:0]  head_pc,
    output logic [size-1:0]  head_data
);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] nfilled;

    // Entry payload: new entries start unfilled, responses land at the fill pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_ptr].pc     <= push_pc;
            entries[tail_ptr].filled <= 1'b0;
        end
        if (fill) begin
            entries[fill_ptr].data   <= fill_data;
            entries[fill_ptr].filled <= 1'b1;
        end
    end

    // Pointers and occupancy; a clear (flush) overrides every same-cycle update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            nfilled  <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            nfilled  <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (fill) fill_ptr <= fill_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            nfilled <= nfilled + CNT_W'(fill) - CNT_W'(pop);
        end
    end

    // Head view is zero whenever nothing deliverable sits at the head.
    always_comb begin
        unfilled    = count - nfilled;
        head_filled = (count != '0) && entries[head_ptr].filled;
        head_pc     = head_filled ? entries[head_ptr].pc   : '0;
        head_data   = head_filled ? entries[head_ptr].data : '0;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer between the PC controller, the I-mem port and decode.
// Optional feature: define JALR_STALL_EN to stop fetching after a decoded JALR
// until execute resolves it (state JALR_WAIT).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int size            = FETCH_XLEN,
    parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] pc_in,
    input  logic            stall_in,
    input  logic            misprediction,
    input  logic            jalr_decoded,
    input  logic            jalr_resolved,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [size-1:0] imem_rdata,
    output logic            pc_hold,
    output logic            instr_valid,
    output logic [size-1:0] instr,
    output logic [size-1:0] instr_pc
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic [CNT_W+1:0] kill_sum;
    logic             run_en_q;
    logic [CNT_W-1:0] count, unfilled;
    logic             head_filled;
    logic [size-1:0]  head_pc, head_data;
    logic             issue, drop, fill, pop, jalr_enter, flush;

    // Stale-response counter never needs to exceed the number of slots.
    function automatic logic [CNT_W-1:0] sat_kill(input logic [CNT_W+1:0] v);
        if (v > (CNT_W+2)'(MAX_OUTSTANDING)) return CNT_W'(MAX_OUTSTANDING);
        return v[CNT_W-1:0];
    endfunction

    // Request, hold, delivery and response routing for the current cycle.
    always_comb begin
        imem_req    = run_en_q & (count < CNT_W'(MAX_OUTSTANDING)) & ~misprediction
                      & (state_q == RUN);
        imem_addr   = pc_in;
        issue       = imem_req & imem_gnt;
        pc_hold     = ~issue & ~misprediction;
        instr_valid = head_filled & ~stall_in & ~misprediction;
        instr       = head_data;
        instr_pc    = head_pc;
        pop         = instr_valid;
`ifdef JALR_STALL_EN
        jalr_enter  = (state_q == RUN) & jalr_decoded & instr_valid;
`else
        jalr_enter  = 1'b0;
`endif
        flush       = misprediction | jalr_enter;
        drop        = imem_rvalid & (kill_cnt_q != '0);
        fill        = imem_rvalid & ~drop & ~flush & (unfilled != '0);
    end

`ifndef JALR_STALL_EN
    logic unused_jalr_decoded;
    assign unused_jalr_decoded = jalr_decoded;
`endif

    // Responses still owed to flushed entries; a same-cycle response retires one of them.
    always_comb begin
        kill_sum = (CNT_W+2)'(kill_cnt_q) + (CNT_W+2)'(unfilled) + (CNT_W+2)'(issue);
        if (imem_rvalid && (kill_sum != '0)) kill_sum = kill_sum - (CNT_W+2)'(1);
    end

    // Next state and kill count; misprediction takes priority over everything else.
    always_comb begin
        state_d    = state_q;
        kill_cnt_d = kill_cnt_q;
        if (flush) begin
            kill_cnt_d = sat_kill(kill_sum);
        end else if (drop) begin
            kill_cnt_d = kill_cnt_q - CNT_W'(1);
        end
        case (state_q)
            RUN:       if (jalr_enter) state_d = JALR_WAIT;
            JALR_WAIT: if (misprediction || jalr_resolved) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    // Control registers; run_en keeps requests off until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            kill_cnt_q <= '0;
            run_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_cnt_q <= kill_cnt_d;
            run_en_q   <= 1'b1;
        end
    end

    // Responses must always have an owner and the kill count must never saturate.
    always_ff @(posedge clk) begin
        if (reset && imem_rvalid && !drop && !flush) assert (unfilled != '0);
        if (reset && flush) assert (kill_sum <= (CNT_W+2)'(MAX_OUTSTANDING));
    end

    fetch_buffer #(
        .size  (size),
        .DEPTH (MAX_OUTSTANDING)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .push        (issue),
        .push_pc     (pc_in),
        .fill        (fill),
        .fill_data   (imem_rdata),
        .pop         (pop),
        .count       (count),
        .unfilled    (unfilled),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_data   (head_data)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural PC controller, in-order memory and an
// expected-delivery queue; directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    typedef struct {
        logic [31:0] pc;
        int          gen;
        int          cyc;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = '0;
    logic        stall_in = 1'b0, misprediction = 1'b0;
    logic        jalr_decoded = 1'b0, jalr_resolved = 1'b0;
    logic        imem_req, pc_hold, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int gen   = 0;

    logic [31:0] pc_model, mp_target;
    logic        k_gnt, k_resp, k_stall, k_mp, k_jalr, k_jres;
    req_t        mem_q[$];
    req_t        exp_q[$];

    logic        o_req, o_hold, o_ivalid, o_issue, e_has;
    logic [31:0] o_addr, o_instr, o_ipc, e_pc, e_instr;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .stall_in      (stall_in),
        .misprediction (misprediction),
        .jalr_decoded  (jalr_decoded),
        .jalr_resolved (jalr_resolved),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_hold       (pc_hold),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] data_of(logic [31:0] pc, int g);
        return pc ^ (32'h9E37_79B9 * 32'(g)) ^ 32'h0BAD_F00D;
    endfunction

    // One clock: drive inputs just after posedge, sample at negedge, update models.
    task automatic cycle();
        req_t r;
        logic jflush;
        pc_in         = pc_model;
        imem_gnt      = k_gnt;
        stall_in      = k_stall;
        misprediction = k_mp;
        jalr_resolved = k_jres;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        if (k_resp && mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
            r           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(r.pc, r.gen);
        end
        #1;
        jalr_decoded = k_jalr & instr_valid;
        @(negedge clk);
        o_req    = imem_req;
        o_addr   = imem_addr;
        o_hold   = pc_hold;
        o_ivalid = instr_valid;
        o_instr  = instr;
        o_ipc    = instr_pc;
        o_issue  = o_req & imem_gnt;
        e_has    = 1'b0;
        if (o_ivalid && exp_q.size() > 0) begin
            r       = exp_q.pop_front();
            e_has   = 1'b1;
            e_pc    = r.pc;
            e_instr = data_of(r.pc, r.gen);
        end
        if (o_issue) begin
            r.pc  = o_addr;
            r.gen = gen;
            r.cyc = cyc;
            mem_q.push_back(r);
            exp_q.push_back(r);
        end
`ifdef JALR_STALL_EN
        jflush = jalr_decoded;
`else
        jflush = 1'b0;
`endif
        if (k_mp || jflush) begin
            gen++;
            exp_q.delete();
        end
        if (k_mp) pc_model = mp_target;
        else if (!o_hold) pc_model = pc_model + 32'd4;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        reset = 1'b0;
        {k_gnt, k_resp, k_stall, k_mp, k_jalr, k_jres} = '0;
        mem_q.delete();
        exp_q.delete();
        pc_model = pc;
        pc_in = pc;
        {imem_gnt, imem_rvalid, misprediction, stall_in, jalr_decoded, jalr_resolved} = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset(32'h0);
        k_gnt = 1'b1;
        k_resp = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (pc_hold !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b want 1", pc_hold); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_ivalid: got %b want 0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        mem_q.delete();
        exp_q.delete();
        pc_model = 32'h100;
        pc_in = 32'h100;
        imem_rvalid = 1'b0;
        imem_gnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        k_gnt = 1'b0;
        cycle();
        total++; if (o_req !== 1'b0) begin bad++; $display("FAIL reset_release_req: got %b want 0", o_req); end
        cycle();
        total++;
        if (o_req !== 1'b1 || o_addr !== 32'h100) begin
            bad++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=00000100", o_req, o_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        int dcyc [3];
        int nd = 0;
        for (int i = 0; i < 3; i++) begin pcs[i] = '1; ins[i] = '1; dcyc[i] = -9; end
        do_reset(32'h0);
        k_gnt = 1'b1;
        k_resp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_ivalid && nd < 3) begin
                pcs[nd] = o_ipc; ins[nd] = o_instr; dcyc[nd] = cyc; nd++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pcs[i] !== 32'(i * 4) || ins[i] !== data_of(32'(i * 4), gen)) begin
                bad++;
                $display("FAIL stream_%0d: got pc=%h instr=%h want pc=%h instr=%h",
                         i, pcs[i], ins[i], 32'(i * 4), data_of(32'(i * 4), gen));
            end
        end
        total++;
        if (dcyc[1] !== dcyc[0] + 1) begin
            bad++; $display("FAIL stream_back_to_back: got gap=%0d want 1", dcyc[1] - dcyc[0]);
        end
    endtask

    task automatic test_hold();
        do_reset(32'h300);
        k_resp = 1'b1;
        k_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (o_hold !== 1'b1 || o_addr !== 32'h300 || o_req !== 1'b1) begin
                bad++; $display("FAIL hold_wait_%0d: got hold=%b addr=%h req=%b want 1 00000300 1", i, o_hold, o_addr, o_req);
            end
        end
        k_gnt = 1'b1;
        cycle();
        total++; if (o_hold !== 1'b0) begin bad++; $display("FAIL hold_grant: got %b want 0", o_hold); end
        k_gnt = 1'b0;
        cycle();
        total++;
        if (o_hold !== 1'b1 || o_addr !== 32'h304) begin
            bad++; $display("FAIL hold_after: got hold=%b addr=%h want 1 00000304", o_hold, o_addr);
        end
    endtask

    task automatic test_stall();
        do_reset(32'h0);
        k_stall = 1'b1;
        k_gnt = 1'b1;
        k_resp = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        cycle();
        total++;
        if (o_req !== 1'b0 || o_ivalid !== 1'b0 || o_ipc !== 32'h0 || o_instr !== data_of(32'h0, gen)) begin
            bad++; $display("FAIL stall_full: got req=%b ivalid=%b pc=%h instr=%h want 0 0 00000000 %h",
                            o_req, o_ivalid, o_ipc, o_instr, data_of(32'h0, gen));
        end
        k_stall = 1'b0;
        cycle();
        total++;
        if (o_ivalid !== 1'b1 || o_ipc !== 32'h0) begin
            bad++; $display("FAIL stall_release0: got ivalid=%b pc=%h want 1 00000000", o_ivalid, o_ipc);
        end
        cycle();
        total++;
        if (o_ivalid !== 1'b1 || o_ipc !== 32'h4) begin
            bad++; $display("FAIL stall_release1: got ivalid=%b pc=%h want 1 00000004", o_ivalid, o_ipc);
        end
    endtask

    task automatic test_mispredict();
        logic seen = 1'b0;
        do_reset(32'h0);
        k_gnt = 1'b1;
        k_resp = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        k_mp = 1'b1;
        mp_target = 32'h200;
        cycle();
        total++;
        if (o_req !== 1'b0 || o_hold !== 1'b0) begin
            bad++; $display("FAIL mp_cycle: got req=%b hold=%b want 0 0", o_req, o_hold);
        end
        k_mp = 1'b0;
        k_resp = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (o_ivalid) begin
                seen = 1'b1;
                total++;
                if (o_ipc !== 32'h200 || o_instr !== data_of(32'h200, gen)) begin
                    bad++; $display("FAIL mp_first: got pc=%h instr=%h want 00000200 %h",
                                    o_ipc, o_instr, data_of(32'h200, gen));
                end
            end
        end
        if (!seen) begin
            total++; bad++; $display("FAIL mp_timeout: got no delivery want pc 00000200");
        end
    endtask

    task automatic test_jalr();
        logic seen = 1'b0;
        do_reset(32'h40);
        k_gnt = 1'b1;
        k_resp = 1'b1;
        k_jalr = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (o_ivalid) seen = 1'b1;
        end
        k_jalr = 1'b0;
        total++;
        if (!seen || o_ipc !== 32'h40) begin
            bad++; $display("FAIL jalr_deliver: got seen=%b pc=%h want 1 00000040", seen, o_ipc);
        end
`ifdef JALR_STALL_EN
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++; if (o_req !== 1'b0) begin bad++; $display("FAIL jalr_wait_%0d: got req=%b want 0", i, o_req); end
        end
        k_jres = 1'b1;
        cycle();
        k_jres = 1'b0;
        cycle();
        total++; if (o_req !== 1'b1) begin bad++; $display("FAIL jalr_resume: got req=%b want 1", o_req); end
`else
        cycle();
        total++; if (o_req !== 1'b1) begin bad++; $display("FAIL jalr_ignored: got req=%b want 1", o_req); end
`endif
    endtask

    task automatic test_random();
        int stale;
        logic [31:0] t;
        do_reset(32'h1000);
        for (int i = 0; i < 800; i++) begin
            k_gnt   = ($urandom % 10) < 6;
            k_resp  = ($urandom % 10) < 7;
            k_stall = ($urandom % 10) < 3;
            stale = 0;
            foreach (mem_q[j]) if (mem_q[j].gen != gen) stale++;
            k_mp = (stale == 0) && (($urandom % 100) < 4);
            t = $urandom;
            t[1:0] = 2'b00;
            mp_target = t;
            cycle();
            if (o_ivalid) begin
                total++;
                if (!e_has) begin
                    bad++; $display("FAIL rand_unexpected: got pc=%h want no delivery", o_ipc);
                end else if (o_ipc !== e_pc || o_instr !== e_instr) begin
                    bad++; $display("FAIL rand_deliver: got pc=%h instr=%h want %h %h", o_ipc, o_instr, e_pc, e_instr);
                end
            end
            if (k_stall || k_mp) begin
                total++; if (o_ivalid !== 1'b0) begin bad++; $display("FAIL rand_blocked: got ivalid=%b want 0", o_ivalid); end
            end
            if (k_mp) begin
                total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rand_mp_req: got %b want 0", o_req); end
            end else begin
                total++; if (o_hold !== ~o_issue) begin bad++; $display("FAIL rand_hold: got %b want %b", o_hold, ~o_issue); end
            end
            if (o_req) begin
                total++; if (o_addr !== pc_in) begin bad++; $display("FAIL rand_addr: got %h want %h", o_addr, pc_in); end
            end
        end
        {k_gnt, k_stall, k_mp} = '0;
        k_resp = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_q.size() > 0); i++) begin
            cycle();
            if (o_ivalid) begin
                total++;
                if (!e_has || o_ipc !== e_pc || o_instr !== e_instr) begin
                    bad++; $display("FAIL drain_deliver: got pc=%h instr=%h want %h %h", o_ipc, o_instr, e_pc, e_instr);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL drain_empty: got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        {k_gnt, k_resp, k_stall, k_mp, k_jalr, k_jres} = '0;
        pc_model = '0;
        mp_target = '0;
        test_reset();
        test_stream();
        test_hold();
        test_stall();
        test_mispredict();
        test_jalr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
